// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Debounces one raw, asynchronous, active-high push-button
//                input. The level is brought into the clk domain through a
//                flop synchronizer, then must stay high for DEBOUNCE_CYCLES
//                consecutive clocks before a single one-cycle press event is
//                emitted. Any low cycle restarts qualification, and holding
//                the button past the threshold never produces a repeat.
//
//  Ports       : clk    - system clock, all logic on the rising edge
//                rst_n  - synchronous, active-low reset
//                btn_i  - raw button level (asynchronous, may bounce)
//                btn_o  - press event, one clk cycle wide, registered
//
//  Parameters  : DEBOUNCE_CYCLES - qualification length in clk cycles
//                CNT_W           - counter width, 2**CNT_W > DEBOUNCE_CYCLES
//                SYNC_STAGES     - synchronizer depth, at least 2
//
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1048576,
    parameter int CNT_W           = 21,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic btn_o
);

    // Threshold and the value one below it, sized to the counter so the
    // compares below stay width-exact.
    localparam logic [CNT_W-1:0] c_threshold = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_fire_at   = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Input synchronizer. btn_i feeds only the first stage; everything else
    // works on the last stage, so metastability has SYNC_STAGES-1 full
    // cycles to resolve before it can influence the counter.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_btn_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_i};
        end
    end

    assign w_btn_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Qualification counter. Cleared on any low synchronized cycle, counts
    // up while high, and parks at the threshold so a long hold can neither
    // wrap around nor re-trigger the event.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_fire;

    always_comb begin
        w_count_nxt = r_count;
        if (!w_btn_s) begin
            w_count_nxt = '0;
        end else if (r_count < c_threshold) begin
            w_count_nxt = r_count + 1'b1;
        end
    end

    // The event fires on the very increment that lands on the threshold,
    // which happens exactly once per continuous high run.
    assign w_fire = w_btn_s && (r_count == c_fire_at);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Registered output: no combinational path from btn_i to btn_o.
    // ------------------------------------------------------------------------
    logic r_btn_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_btn_o <= 1'b0;
        end else begin
            r_btn_o <= w_fire;
        end
    end

    assign btn_o = r_btn_o;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debounce
//  Description : Self-checking bench for button_debounce with a shortened
//                qualification time (16 cycles, 5-bit counter). Each press
//                that should qualify pushes its expected event cycle into a
//                scoreboard queue; every observed btn_o pulse pops and
//                compares, and each scenario ends by checking nothing is
//                still outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

    localparam int D  = 16;
    localparam int CW = 5;
    localparam int SS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic btn_i = 1'b0;
    logic btn_o;

    always #10 clk = ~clk;

    button_debounce #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW),
        .SYNC_STAGES    (SS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn_i(btn_i),
        .btn_o(btn_o)
    );

    // Rising-edge counter: the event for a high level first driven while
    // cyc==c0 is expected on the edge numbered c0 + D + 2 (two synchronizer
    // stages, D counting cycles, registered output).
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int exp_q[$];
    int checks   = 0;
    int passes   = 0;
    bit in_reset = 1'b0;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (in_reset) begin
            checks++;
            if (btn_o !== 1'b0)
                $display("FAIL reset_low: btn_o=%b at cycle %0d, required 0", btn_o, cyc);
            else
                passes++;
        end else if (btn_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: btn_o=1 at cycle %0d, required no pulse", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (e == cyc)
                    passes++;
                else
                    $display("FAIL pulse_time: pulse at cycle %0d, required cycle %0d", cyc, e);
            end
        end
    end

    // Drive a level for n cycles; when the caller expects this high run to
    // qualify, its event time goes on the scoreboard now.
    task automatic drive(input logic v, input int n, input bit expect_pulse);
        btn_i = v;
        if (expect_pulse) exp_q.push_back(cyc + D + 2);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold reset for n rising edges with btn_i left untouched.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        in_reset = 1'b1;
        repeat (n - 1) begin
            @(posedge clk);
            #1;
        end
        rst_n    = 1'b1;
        in_reset = 1'b0;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() == 0)
            passes++;
        else
            $display("FAIL %s: %0d expected pulse(s) never seen, required 0", name, exp_q.size());
        exp_q.delete();
    endtask

    typedef struct {
        string name;
        int    high;
        int    low;
        bit    exp_pulse;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"short_d_minus_1", D - 1, 6, 1'b0};
        vecs[1] = '{"exact_d",         D,     6, 1'b1};
        vecs[2] = '{"d_plus_1",        D + 1, 6, 1'b1};
        vecs[3] = '{"single_cycle",    1,     6, 1'b0};
        vecs[4] = '{"long_hold",       60,    6, 1'b1};
        vecs[5] = '{"two_cycle",       2,     6, 1'b0};

        // Reset with the button already held, then one event after release.
        btn_i = 1'b1;
        do_reset(5);
        exp_q.push_back(cyc + D + 2);
        repeat (D + 10) begin
            @(posedge clk);
            #1;
        end
        drive(1'b0, 6, 1'b0);
        check_drained("reset_release");

        // Table of single presses.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].high, vecs[i].exp_pulse);
            drive(1'b0, vecs[i].low, 1'b0);
            check_drained(vecs[i].name);
        end

        // Two valid presses separated by a single low cycle.
        drive(1'b1, D, 1'b1);
        drive(1'b0, 1, 1'b0);
        drive(1'b1, D, 1'b1);
        drive(1'b0, 6, 1'b0);
        check_drained("back_to_back");

        // Long total high time split by one-cycle gaps: never qualifies.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 10, 1'b0);
            drive(1'b0, 1, 1'b0);
        end
        drive(1'b1, 10, 1'b0);
        drive(1'b0, 6, 1'b0);
        check_drained("interrupted");

        // Bounce, then a steady hold: one event timed from the final rise.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2, 1'b0);
            drive(1'b0, 2, 1'b0);
        end
        drive(1'b1, 30, 1'b1);
        drive(1'b0, 6, 1'b0);
        check_drained("bounce_then_hold");

        // Reset mid-press aborts it; counting restarts after release.
        drive(1'b1, 10, 1'b0);
        do_reset(2);
        exp_q.push_back(cyc + D + 2);
        repeat (D + 6) begin
            @(posedge clk);
            #1;
        end
        drive(1'b0, 6, 1'b0);
        check_drained("reset_mid_press");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Debounces one raw, asynchronous push-button input. Emits a single-clock pulse when the button has been held continuously for a qualification time (≈21 ms at 50 MHz).
- Rejects contact bounce, glitches and presses that are too short.
- Sits between a board push-button pin and control logic that needs one clean event per press.

Parameters:
- DEBOUNCE_CYCLES, 1048576, number of consecutive clock cycles the synchronized input must be high before a press is accepted (2^20 ≈ 20.97 ms at 50 MHz).
- CNT_W, 21, counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock (50 MHz nominal); all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- btn_i  input  1  raw button level, active-high, asynchronous to clk, may bounce.
- btn_o  output  1  press event, active-high, one clk cycle wide.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-low.
  - While rst_n=0 at a rising edge: all synchronizer flops=0, counter=0, btn_o=0.
  - Reset asserted mid-press aborts the press: no pulse; counting restarts from 0 after release of reset.
- Synchronizer:
  - btn_i passes through a SYNC_STAGES flop chain.
  - btn_s is the last stage.
  - No logic acts on btn_i directly.
- Counter (CNT_W bits, unsigned):
  - btn_s=0 → counter <= 0. Any low cycle, even one, fully restarts qualification.
  - btn_s=1 and counter < DEBOUNCE_CYCLES → counter <= counter+1.
  - btn_s=1 and counter = DEBOUNCE_CYCLES → hold (saturate, never wraps).
- Output (registered):
  - btn_o <= 1 iff btn_s=1 and counter = DEBOUNCE_CYCLES-1 (the increment that reaches the threshold). Otherwise btn_o <= 0.
  - Exactly one pulse per continuous press regardless of hold length. Holding beyond the threshold produces no repeats.
  - A new pulse requires btn_s to go low (counter cleared) and then high again for DEBOUNCE_CYCLES cycles.
- Latency:
  - The btn_o rising edge occurs SYNC_STAGES+DEBOUNCE_CYCLES clock edges (±1) after the first clk edge that samples btn_i=1 and stays high.
  - No dependency on the release timing.
- Boundary conditions:
  - A press lasting DEBOUNCE_CYCLES-1 synchronized cycles produces no pulse.
  - A press lasting exactly DEBOUNCE_CYCLES cycles produces one pulse.
  - Glitches shorter than one clk period may be missed by the synchronizer; that is acceptable (either outcome is legal).
  - Release in the same cycle that the threshold is reached: pulse determined solely by the btn_s/counter rule above.
- No combinational path from btn_i to btn_o.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with btn_i=1 → btn_o=0 throughout; after rst_n=1 with btn_i=1, exactly one pulse ≈ DEBOUNCE_CYCLES+2 cycles later.
- Too short (clk 20 ns): btn_i=1 for 20 ms (1,000,000 cycles < 1,048,576), then 0 for 10 ms → btn_o never asserted.
- Interrupted: four 5 ms highs separated by 100 ns lows (5 clocks), then low 10 ms → no pulse; counter returns to 0 at each gap.
- Bounce then hold: six alternating 1 µs high/low segments, then btn_i=1 for 25 ms → exactly one 20 ns pulse ≈ 20.97 ms after the final rising edge; none during bounce.
- Long press: btn_i=1 for 40 ms, then 0 for 10 ms → exactly one pulse at ≈ 20.97 ms; no repeat during the remaining 19 ms or at release.
- Threshold edge: with DEBOUNCE_CYCLES overridden to 16, a press of 15 synchronized cycles → no pulse; 16 cycles → one pulse; two valid presses separated by one low cycle → two pulses.
